// File: rtl/mux_rate_pkg.sv
// Shared definitions for the mux-rate monitor link: header constants,
// frame lengths, error bit positions, FSM state encoding and the
// expected-header-byte helper.
`timescale 1ns/1ps
package mux_rate_pkg;

   localparam int unsigned CMD_W     = 48;
   localparam int unsigned QUERY_LEN = 10;
   localparam int unsigned HDR_LEN   = 8;
   localparam int unsigned ERR_W     = 3;

   localparam logic [7:0] HDR0 = 8'h04;
   localparam logic [7:0] HDR1 = 8'h0a;

   localparam int unsigned ERR_HDR = 0;  // header or echo mismatch
   localparam int unsigned ERR_LEN = 1;  // length mismatch or start>end
   localparam int unsigned ERR_TMO = 2;  // no reply within TIMEOUT

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_HDR,
      ST_DATA,
      ST_FIN
   } state_t;

   // Expected reply header byte idx: two fixed bytes, then the echoed command.
   function automatic logic [7:0] hdr_expect(input logic [2:0] idx,
                                             input logic [CMD_W-1:0] cmd);
      logic [CMD_W-1:0] sh;
      sh = cmd >> (8 * (7 - 32'(idx)));
      case (idx)
         3'd0:    return HDR0;
         3'd1:    return HDR1;
         default: return sh[7:0];
      endcase
   endfunction

endpackage

// File: rtl/mux_rate_query_tx.sv
// Query frame serialiser. A load pulse captures the command and address
// fields and drives them out as 10 contiguous bytes, first byte in the
// cycle after load.
//   clk, rst        clock, synchronous active-high reset
//   load            capture fields and start the frame
//   cmd             6 command bytes, [47:40] sent first
//   start_addr      first word address (sent as 2 bytes, upper nibble 0)
//   end_addr        last word address (sent as 2 bytes, upper nibble 0)
//   dout, dout_en   frame byte and valid
//   last_c          final frame byte is on dout this cycle
`timescale 1ns/1ps
module mux_rate_query_tx
   import mux_rate_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [CMD_W-1:0]  cmd,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [7:0]        dout,
   output logic              dout_en,
   output logic              last_c
);

   localparam int unsigned FRAME_W = QUERY_LEN * 8;
   localparam int unsigned REST_W  = FRAME_W - 8;

   logic [FRAME_W-1:0] frame;
   logic [REST_W-1:0]  rest_q;
   logic [3:0]         left_q;

   assign frame  = {cmd, 16'(start_addr), 16'(end_addr)};
   assign last_c = dout_en && (left_q == 4'd0);

   // Byte 0 goes straight to dout on load; the remaining 9 shift out behind it.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout    <= '0;
         dout_en <= 1'b0;
         rest_q  <= '0;
         left_q  <= '0;
      end else if (load) begin
         dout    <= frame[FRAME_W-1 -: 8];
         rest_q  <= frame[REST_W-1:0];
         left_q  <= 4'(QUERY_LEN - 1);
         dout_en <= 1'b1;
      end else if (dout_en) begin
         if (left_q != 4'd0) begin
            dout   <= rest_q[REST_W-1 -: 8];
            rest_q <= {rest_q[REST_W-9:0], 8'h00};
            left_q <= left_q - 4'd1;
         end else begin
            dout    <= '0;
            dout_en <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_rate_query_host.sv
// Initiator side of the mux-rate monitor link. Sends a query frame, then
// checks the reply header/echo and reassembles the payload into indexed
// 16-bit rate words.
//   clk, rst                 clock, synchronous active-high reset
//   req, req_cmd,
//   req_start, req_end       query request and its fields (sampled in IDLE)
//   busy                     transaction in progress
//   con_dout, con_dout_en    query frame bytes to the monitor
//   rate_din, rate_din_en    reply bytes from the monitor
//   word_dout, word_dout_en,
//   word_idx                 reassembled rate word and its address
//   done                     one-cycle completion pulse
//   err                      {timeout, length, header} status
`timescale 1ns/1ps
module mux_rate_query_host
   import mux_rate_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [CMD_W-1:0]  req_cmd,
   input  logic [ADDR_W-1:0] req_start,
   input  logic [ADDR_W-1:0] req_end,
   output logic              busy,
   output logic [7:0]        con_dout,
   output logic              con_dout_en,
   input  logic [7:0]        rate_din,
   input  logic              rate_din_en,
   output logic [15:0]       word_dout,
   output logic              word_dout_en,
   output logic [ADDR_W-1:0] word_idx,
   output logic              done,
   output logic [ERR_W-1:0]  err
);

   localparam int unsigned N_W      = ADDR_W + 1;
   localparam int unsigned BC_W     = ADDR_W + 2;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t state, state_nx;

   logic [CMD_W-1:0]  cmd_q;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] end_q;
   logic [15:0]       tmo_cnt;
   logic [2:0]        hdr_cnt;
   logic [BC_W-1:0]   bcnt_q;
   logic [7:0]        hi_q;
   logic [N_W-1:0]    n_words;
   logic [BC_W-1:0]   byte_total;
   logic              tx_load_c;
   logic              tx_last_c;

   logic [ERR_W-1:0]  err_d;
   logic [15:0]       word_d;
   logic              word_en_d;
   logic [ADDR_W-1:0] idx_d;

   // Payload length in bytes: two per word, end inclusive.
   assign n_words    = N_W'({1'b0, end_q}) - N_W'({1'b0, start_q}) + N_W'(1);
   assign byte_total = {n_words, 1'b0};

   mux_rate_query_tx #(.ADDR_W(ADDR_W)) u_tx (
      .clk        (clk),
      .rst        (rst),
      .load       (tx_load_c),
      .cmd        (req_cmd),
      .start_addr (req_start),
      .end_addr   (req_end),
      .dout       (con_dout),
      .dout_en    (con_dout_en),
      .last_c     (tx_last_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (req) state_nx = (req_start > req_end) ? ST_FIN : ST_SEND;
         end
         ST_SEND: begin
            if (tx_last_c) state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (rate_din_en)              state_nx = ST_HDR;
            else if (tmo_cnt == TMO_LAST) state_nx = ST_FIN;
         end
         ST_HDR: begin
            if (!rate_din_en)                     state_nx = ST_FIN;
            else if (hdr_cnt == 3'(HDR_LEN - 1)) state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (!rate_din_en) state_nx = ST_FIN;
         end
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output and status next values; registered below.
   always_comb begin
      err_d     = err;
      word_d    = word_dout;
      word_en_d = 1'b0;
      idx_d     = word_idx;
      tx_load_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               err_d = '0;
               if (req_start > req_end) err_d[ERR_LEN] = 1'b1;
               else                     tx_load_c      = 1'b1;
            end
         end
         ST_WAIT: begin
            if (rate_din_en) begin
               if (rate_din != HDR0) err_d[ERR_HDR] = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               err_d[ERR_TMO] = 1'b1;
            end
         end
         ST_HDR: begin
            if (!rate_din_en)                              err_d[ERR_LEN] = 1'b1;
            else if (rate_din != hdr_expect(hdr_cnt, cmd_q)) err_d[ERR_HDR] = 1'b1;
         end
         ST_DATA: begin
            if (rate_din_en) begin
               if (bcnt_q < byte_total) begin
                  // Odd byte count means this is the lo half of a word.
                  if (bcnt_q[0] && !err[ERR_HDR]) begin
                     word_en_d = 1'b1;
                     word_d    = {hi_q, rate_din};
                     idx_d     = start_q + ADDR_W'(bcnt_q >> 1);
                  end
               end else begin
                  err_d[ERR_LEN] = 1'b1;
               end
            end else if (bcnt_q != byte_total) begin
               err_d[ERR_LEN] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and receive-side datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         err          <= '0;
         word_dout    <= '0;
         word_dout_en <= 1'b0;
         word_idx     <= '0;
         done         <= 1'b0;
         busy         <= 1'b0;
         cmd_q        <= '0;
         start_q      <= '0;
         end_q        <= '0;
         tmo_cnt      <= '0;
         hdr_cnt      <= '0;
         bcnt_q       <= '0;
         hi_q         <= '0;
      end else begin
         err          <= err_d;
         word_dout    <= word_d;
         word_dout_en <= word_en_d;
         word_idx     <= idx_d;
         done         <= (state_nx == ST_FIN);
         busy         <= (state_nx != ST_IDLE);

         if (state == ST_IDLE && req) begin
            cmd_q   <= req_cmd;
            start_q <= req_start;
            end_q   <= req_end;
         end

         // Idle-gap counter is zero whenever WAIT is entered.
         if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
         else                  tmo_cnt <= '0;

         // WAIT consumes header byte 0, so HDR starts at index 1.
         if (state == ST_WAIT)                   hdr_cnt <= 3'd1;
         else if (state == ST_HDR && rate_din_en) hdr_cnt <= hdr_cnt + 3'd1;

         if (state != ST_DATA) begin
            bcnt_q <= '0;
         end else if (rate_din_en && bcnt_q < byte_total) begin
            bcnt_q <= bcnt_q + BC_W'(1);
            if (!bcnt_q[0]) hi_q <= rate_din;
         end
      end
   end

endmodule

// File: tb/tb_mux_rate_query_host.sv
// Directed self-checking bench for mux_rate_query_host (TIMEOUT=16).
// Inputs change just after the falling edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_mux_rate_query_host;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [47:0] req_cmd;
   logic [11:0] req_start;
   logic [11:0] req_end;
   logic        busy;
   logic [7:0]  con_dout;
   logic        con_dout_en;
   logic [7:0]  rate_din;
   logic        rate_din_en;
   logic [15:0] word_dout;
   logic        word_dout_en;
   logic [11:0] word_idx;
   logic        done;
   logic [2:0]  err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  rx [0:15];
   logic [15:0] wv [0:15];
   logic [11:0] wi [0:15];
   int          wcnt;

   localparam logic [47:0] CMD = 48'h010203040506;

   always #5 clk = ~clk;

   mux_rate_query_host #(.ADDR_W(12), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_cmd      (req_cmd),
      .req_start    (req_start),
      .req_end      (req_end),
      .busy         (busy),
      .con_dout     (con_dout),
      .con_dout_en  (con_dout_en),
      .rate_din     (rate_din),
      .rate_din_en  (rate_din_en),
      .word_dout    (word_dout),
      .word_dout_en (word_dout_en),
      .word_idx     (word_idx),
      .done         (done),
      .err          (err)
   );

   task automatic step();
      @(negedge clk);
   endtask

   // Pulse req for one cycle; returns in the cycle after acceptance.
   task automatic send_req(input logic [47:0] c, input logic [11:0] s, input logic [11:0] e);
      req_cmd = c; req_start = s; req_end = e; req = 1'b1;
      step();
      req = 1'b0;
   endtask

   // Standard reply: 04 0a 01..06 12 34 56 78 9a bc.
   task automatic load_std_reply();
      rx[0] = 8'h04; rx[1] = 8'h0a;
      for (int i = 0; i < 6; i++) rx[2+i] = 8'(i + 1);
      rx[8]  = 8'h12; rx[9]  = 8'h34; rx[10] = 8'h56;
      rx[11] = 8'h78; rx[12] = 8'h9a; rx[13] = 8'hbc;
   endtask

   // Drive rx[0..n-1] contiguously, drop valid for one cycle, record words.
   task automatic feed(input int n);
      wcnt = 0;
      for (int i = 0; i < n; i++) begin
         rate_din = rx[i]; rate_din_en = 1'b1;
         step();
         if (word_dout_en) begin
            wv[wcnt] = word_dout; wi[wcnt] = word_idx; wcnt++;
         end
      end
      rate_din_en = 1'b0; rate_din = 8'h00;
      step();
      if (word_dout_en) wcnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++;
      if ({con_dout, con_dout_en, word_dout, word_dout_en, word_idx, done, busy, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got con=%h/%b word=%h/%b idx=%h done=%b busy=%b err=%b, want all 0",
                  con_dout, con_dout_en, word_dout, word_dout_en, word_idx, done, busy, err);
      end
      rst = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_query_format();
      logic [7:0] exp_b [0:9];
      exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h05, 8'h00, 8'h07};
      send_req(CMD, 12'h005, 12'h007);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL query_busy: got %b want 1", busy);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (con_dout_en !== 1'b1 || con_dout !== exp_b[i]) begin
            errors++;
            $display("FAIL query_byte%0d: got en=%b %h want en=1 %h", i, con_dout_en, con_dout, exp_b[i]);
         end
         step();
      end
      checks++;
      if (con_dout_en !== 1'b0) begin
         errors++; $display("FAIL query_end: con_dout_en=%b want 0", con_dout_en);
      end
   endtask

   task automatic test_valid_reply();
      load_std_reply();
      feed(14);
      checks++;
      if (wcnt !== 3) begin
         errors++; $display("FAIL valid_wcnt: got %0d want 3", wcnt);
      end else begin
         checks++;
         if (wv[0] !== 16'h1234 || wi[0] !== 12'h005 || wv[1] !== 16'h5678 || wi[1] !== 12'h006 ||
             wv[2] !== 16'h9abc || wi[2] !== 12'h007) begin
            errors++;
            $display("FAIL valid_words: got %h@%h %h@%h %h@%h want 1234@005 5678@006 9abc@007",
                     wv[0], wi[0], wv[1], wi[1], wv[2], wi[2]);
         end
      end
      checks++;
      if (done !== 1'b1 || err !== 3'b000 || busy !== 1'b1) begin
         errors++; $display("FAIL valid_done: done=%b err=%b busy=%b want 1 000 1", done, err, busy);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== 3'b000) begin
         errors++; $display("FAIL valid_after: done=%b busy=%b err=%b want 0 0 000", done, busy, err);
      end
   endtask

   task automatic test_bad_header();
      send_req(CMD, 12'h005, 12'h007);
      repeat (10) step();
      load_std_reply();
      rx[1] = 8'h0b;
      feed(14);
      checks++;
      if (wcnt !== 0) begin
         errors++; $display("FAIL badhdr_words: got %0d want 0", wcnt);
      end
      checks++;
      if (done !== 1'b1 || err !== 3'b001) begin
         errors++; $display("FAIL badhdr_done: done=%b err=%b want 1 001", done, err);
      end
      step();
   endtask

   task automatic test_short_reply();
      send_req(CMD, 12'h005, 12'h007);
      repeat (10) step();
      load_std_reply();
      feed(13);
      checks++;
      if (wcnt !== 2 || wv[0] !== 16'h1234 || wi[0] !== 12'h005 || wv[1] !== 16'h5678 || wi[1] !== 12'h006) begin
         errors++;
         $display("FAIL short_words: got n=%0d %h@%h %h@%h want 2 1234@005 5678@006",
                  wcnt, wv[0], wi[0], wv[1], wi[1]);
      end
      checks++;
      if (done !== 1'b1 || err !== 3'b010) begin
         errors++; $display("FAIL short_done: done=%b err=%b want 1 010", done, err);
      end
      step();
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      send_req(CMD, 12'h005, 12'h007);
      repeat (9) step();
      checks++;
      if (con_dout_en !== 1'b1 || con_dout !== 8'h07) begin
         errors++; $display("FAIL tmo_lastbyte: en=%b byte=%h want 1 07", con_dout_en, con_dout);
      end
      for (int k = 1; k <= 16; k++) begin
         step();
         if (done) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++; $display("FAIL tmo_early: done seen %0d times before last+17, want 0", early);
      end
      step();
      checks++;
      if (done !== 1'b1 || err !== 3'b100) begin
         errors++; $display("FAIL tmo_done: done=%b err=%b want 1 100", done, err);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL tmo_busy: busy=%b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      send_req(CMD, 12'h009, 12'h003);
      checks++;
      if (done !== 1'b1 || err !== 3'b010 || con_dout_en !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reject_done: done=%b err=%b con_en=%b busy=%b want 1 010 0 1", done, err, con_dout_en, busy);
      end
      // req held across FIN and into the following IDLE cycle
      req_start = 12'h005; req_end = 12'h007; req = 1'b1;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || con_dout_en !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: done=%b busy=%b con_en=%b want 0 0 0", done, busy, con_dout_en);
      end
      step();
      req = 1'b0;
      checks++;
      if (con_dout_en !== 1'b1 || con_dout !== 8'h01 || err !== 3'b000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: con_en=%b byte=%h err=%b busy=%b want 1 01 000 1", con_dout_en, con_dout, err, busy);
      end
      repeat (10) step();
      load_std_reply();
      feed(14);
      checks++;
      if (done !== 1'b1 || err !== 3'b000 || wcnt !== 3) begin
         errors++; $display("FAIL b2b_done: done=%b err=%b words=%0d want 1 000 3", done, err, wcnt);
      end
      step();
   endtask

   task automatic test_busy_ignore();
      send_req(CMD, 12'h005, 12'h007);
      repeat (3) step();
      req_cmd = 48'hffffffffffff; req_start = 12'h000; req_end = 12'h000; req = 1'b1;
      step();
      req = 1'b0;
      repeat (6) step();
      checks++;
      if (con_dout_en !== 1'b0) begin
         errors++; $display("FAIL busy_frame: con_dout_en=%b want 0", con_dout_en);
      end
      req = 1'b1;
      step();
      req = 1'b0;
      load_std_reply();
      feed(14);
      checks++;
      if (done !== 1'b1 || err !== 3'b000 || wcnt !== 3 || wi[0] !== 12'h005) begin
         errors++;
         $display("FAIL busy_reply: done=%b err=%b words=%0d idx0=%h want 1 000 3 005", done, err, wcnt, wi[0]);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      send_req(CMD, 12'h005, 12'h007);
      repeat (10) step();
      load_std_reply();
      for (int i = 0; i < 10; i++) begin
         rate_din = rx[i]; rate_din_en = 1'b1;
         step();
      end
      checks++;
      if (word_dout_en !== 1'b1 || word_dout !== 16'h1234) begin
         errors++; $display("FAIL rstmid_pre: word_en=%b word=%h want 1 1234", word_dout_en, word_dout);
      end
      rate_din = rx[10]; rst = 1'b1;
      step();
      checks++;
      if ({con_dout, con_dout_en, word_dout, word_dout_en, word_idx, done, busy, err} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs: con=%h/%b word=%h/%b idx=%h done=%b busy=%b err=%b want all 0",
                  con_dout, con_dout_en, word_dout, word_dout_en, word_idx, done, busy, err);
      end
      rst = 1'b0; rate_din_en = 1'b0; rate_din = 8'h00;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++; $display("FAIL rstmid_done: done pulses %0d want 0", dones);
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; req_cmd = '0; req_start = '0; req_end = '0;
      rate_din = '0; rate_din_en = 1'b0;
      test_reset();
      test_query_format();
      test_valid_reply();
      test_bad_header();
      test_short_reply();
      test_timeout();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
